reg_wr_arbiter: RTL and testbench
=================================

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 SHALL have parameter N, default 16, width of data words and of the register-bank write data.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port req, input, 3, write request per requester 0..2.
REQ-005 SHALL have port req_sel, input, 6, target register index per requester; requester i uses bits [2i+1:2i].
REQ-006 SHALL have port req_data, input, 3*N, write data per requester; requester i uses bits [N*i+N-1:N*i].
REQ-007 SHALL have port ack, output, 3, one-cycle write-accepted pulse per requester.
REQ-008 SHALL have port w, output, 1, write enable to the 4-entry register bank.
REQ-009 SHALL have port select_register, output, 2, bank write index.
REQ-010 SHALL have port s, output, N, bank write data.
REQ-011 SHALL have port busy, output, 1, high when any unmasked request is pending.

Function
REQ-012 SHALL use a 2-state FSM: IDLE (no grant issued last cycle) and GRANT (w=1 this cycle).
REQ-013 SHALL sample req on each rising edge and, if any eligible request exists, register exactly one winner: w=1, select_register=req_sel[winner], s=req_data[winner], ack[winner]=1, state=GRANT.
REQ-014 SHALL, when no eligible request exists, register w=0 and ack=000 and go to IDLE; select_register and s hold their last values.
REQ-015 SHALL give latency of exactly one clock: req sampled at edge k -> w/ack high in cycle following edge k.
REQ-016 SHALL arbitrate round-robin with a 2-bit pointer P in {0,1,2}: search order P, P+1, P+2 mod 3; after granting i, P = (i+1) mod 3.
REQ-017 SHALL mask the requester whose ack is currently high from the next arbitration, preventing a double write from a held req.
REQ-018 Requesters SHALL hold req, req_sel, req_data stable until ack seen; they deassert req or present new data at the edge ending the ack cycle.
REQ-019 SHALL sustain one bank write per cycle when at least two requesters are active (alternating slots); a single requester alone gets one write every two cycles.
REQ-020 SHALL never assert more than one ack bit, and ack SHALL equal w-qualified winner (ack!=000 iff w=1).
REQ-021 SHALL compute busy combinationally as |(req & ~ack).
REQ-022 SHALL ignore req_sel/req_data of non-winning requesters; pointer P SHALL never take value 3 (treated as 0 if reached).

Reset
REQ-023 SHALL on rst=0 immediately clear: w=0, ack=000, select_register=00, s=0, P=0, state=IDLE.
REQ-024 SHALL, when reset asserts mid-grant, abort the write (w falls without waiting for clk); requester retries because no ack completed.
REQ-025 SHALL resume arbitration at the first rising clk after rst returns to 1, requester 0 first in priority.

Configuration
REQ-026 SHALL compile a lock feature only when macro WR_ARB_LOCK_EN is defined.
REQ-027 With WR_ARB_LOCK_EN: input lock (3 bits) exists; granting i with lock[i]=1 leaves P=i, so i wins again at its next eligible slot over others.
REQ-028 Without WR_ARB_LOCK_EN: no lock port; pure round-robin per REQ-016.

Verification
REQ-029 Reset: rst=0 with req=111 -> w=0, ack=000, s=0, select_register=00 asynchronously, held until rst=1.
REQ-030 Single: req=001, sel0=2, data0=0x00AA -> next cycle w=1, select_register=2, s=0x00AA, ack=001; following cycle w=0 despite req held.
REQ-031 Round-robin: req=111 held, data i=0x10+i -> grant order 0,1,2,0,1,2 with w=1 every cycle, ack one-hot.
REQ-032 Mid-grant reset: req=010 granted, rst=0 during w=1 -> w=0 and ack=000 at once; after release requester 1 granted again.
REQ-033 Lock (macro defined): req=011, lock=001 -> grant order 0,1,0,1 with 0 winning each of its eligible slots; lock=000 restores 0,1,0,1 by pointer.
REQ-034 Idle hold: after write sel=3 data=0x1234, req=000 for 4 cycles -> w=0, select_register=3, s=0x1234, busy=0.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
// Three-requester round-robin write arbiter for a 4-entry register bank.
// Optional sticky-pointer lock input is compiled in when WR_ARB_LOCK_EN is defined.
module reg_wr_arbiter #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     req,
  input  logic [5:0]     req_sel,
  input  logic [3*N-1:0] req_data,
`ifdef WR_ARB_LOCK_EN
  input  logic [2:0]     lock,
`endif
  output logic [2:0]     ack,
  output logic           w,
  output logic [1:0]     select_register,
  output logic [N-1:0]   s,
  output logic           busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [2:0]     ack_q, ack_d;
  logic [1:0]     sel_q, sel_d;
  logic [N-1:0]   s_q, s_d;

  logic [2:0]     eligible;
  logic [1:0]     ptr_eff;
  logic [1:0]     win;
  logic [1:0]     win_next;
  logic           win_lock;

  // First set bit of el searching from index p upward, wrapping mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] el, input logic [1:0] p);
    logic [2:0] rot;
    logic [1:0] off;
    logic [2:0] sum;
    case (p)
      2'd1:    rot = {el[0], el[2], el[1]};
      2'd2:    rot = {el[1], el[0], el[2]};
      default: rot = el;
    endcase
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else             off = 2'd2;
    sum = {1'b0, p} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  // The requester acked this cycle is still holding req; keep it out.
  assign eligible = req & ~ack_q;
  assign ptr_eff  = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
  assign win      = rr_pick(eligible, ptr_eff);
  assign win_next = (win == 2'd2) ? 2'd0 : win + 2'd1;

`ifdef WR_ARB_LOCK_EN
  assign win_lock = lock[win];
`else
  assign win_lock = 1'b0;
`endif

  always_comb begin
    state_d = IDLE;
    ptr_d   = ptr_eff;
    ack_d   = 3'b000;
    sel_d   = sel_q;
    s_d     = s_q;
    if (eligible != 3'b000) begin
      state_d = GRANT;
      ack_d   = 3'b001 << win;
      sel_d   = req_sel[2*win +: 2];
      s_d     = req_data[N*win +: N];
      ptr_d   = win_lock ? win : win_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      ack_q   <= 3'b000;
      sel_q   <= 2'd0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      s_q     <= s_d;
    end
  end

  assign w               = (state_q == GRANT);
  assign ack             = ack_q;
  assign select_register = sel_q;
  assign s               = s_q;
  assign busy            = |(req & ~ack_q);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed and randomized checks of reg_wr_arbiter against a behavioural model.
module tb_reg_wr_arbiter;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     req;
  logic [5:0]     req_sel;
  logic [3*N-1:0] req_data;
  logic [2:0]     lock;
  logic [2:0]     ack;
  logic           w;
  logic [1:0]     select_register;
  logic [N-1:0]   s;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_p;
  logic [2:0]  m_ack;
  logic        m_w;
  logic [1:0]  m_sel;
  logic [N-1:0] m_s;

  always #5 clk = ~clk;

  reg_wr_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel), .req_data(req_data),
`ifdef WR_ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .w(w), .select_register(select_register), .s(s), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_ack = 3'b000; m_w = 1'b0; m_sel = 2'd0; m_s = '0;
  endtask

  // One arbitration decision as the rules describe it: rotate from P, skip the acked one.
  task automatic model_edge();
    logic [2:0] elig;
    int win;
    elig = req & ~m_ack;
    win = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_p + k) % 3;
      if (win < 0 && elig[idx]) win = idx;
    end
    if (win >= 0) begin
      m_w   = 1'b1;
      m_ack = 3'b000;
      m_ack[win] = 1'b1;
      m_sel = req_sel[2*win +: 2];
      m_s   = req_data[N*win +: N];
`ifdef WR_ARB_LOCK_EN
      m_p   = lock[win] ? win : (win + 1) % 3;
`else
      m_p   = (win + 1) % 3;
`endif
    end else begin
      m_w   = 1'b0;
      m_ack = 3'b000;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".w"},    w,               m_w);
    chk({tag, ".ack"},  ack,             m_ack);
    chk({tag, ".sel"},  select_register, m_sel);
    chk({tag, ".s"},    s,               m_s);
    chk({tag, ".busy"}, busy,            |(req & ~m_ack));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req = 3'b111; lock = 3'b000;
    req_sel = 6'b111001; req_data = {16'h0012, 16'h0011, 16'h0010};
    model_reset();

    // reset holds outputs low even with all requests up
    #1;
    chk("rst.w", w, 1'b0); chk("rst.ack", ack, 3'b000);
    chk("rst.sel", select_register, 2'd0); chk("rst.s", s, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold.w", w, 1'b0); chk("rst_hold.ack", ack, 3'b000);
    chk("rst_hold.s", s, 16'h0000);

    // single requester: one write, then masked while req still held
    @(negedge clk);
    req = 3'b001; req_sel = 6'b000010; req_data = {16'h0, 16'h0, 16'h00AA};
    rst = 1'b1;
    step();
    chk("single.w", w, 1'b1); chk("single.sel", select_register, 2'd2);
    chk("single.s", s, 16'h00AA); chk("single.ack", ack, 3'b001);
    chk_model("single");
    step();
    chk("single2.w", w, 1'b0); chk("single2.ack", ack, 3'b000);
    chk_model("single2");
    req = 3'b000;

    // round robin with all three held
    do_reset();
    req = 3'b111; req_sel = 6'b100100; req_data = {16'h0012, 16'h0011, 16'h0010};
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr.w", w, 1'b1);
      chk("rr.ack", ack, 3'b001 << (k % 3));
      chk("rr.s", s, 16'h0010 + 16'(k % 3));
      chk_model("rr");
    end

    // idle hold after a write
    req = 3'b001; req_sel = 6'b000011; req_data = {16'h0, 16'h0, 16'h1234};
    step();
    chk("idle_wr.w", w, 1'b1); chk("idle_wr.s", s, 16'h1234);
    chk_model("idle_wr");
    req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("idle.w", w, 1'b0); chk("idle.sel", select_register, 2'd3);
      chk("idle.s", s, 16'h1234); chk("idle.busy", busy, 1'b0);
      chk_model("idle");
    end

    // mid-grant reset aborts immediately; requester 1 wins again afterward
    do_reset();
    req = 3'b010; req_sel = 6'b000100; req_data = {16'h0, 16'h0BEE, 16'h0};
    step();
    chk("mid.w", w, 1'b1); chk("mid.ack", ack, 3'b010);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("mid_abort.w", w, 1'b0); chk("mid_abort.ack", ack, 3'b000);
    chk("mid_abort.s", s, 16'h0000);
    @(posedge clk); #1;
    chk("mid_hold.w", w, 1'b0);
    @(negedge clk) rst = 1'b1;
    step();
    chk("mid_retry.w", w, 1'b1); chk("mid_retry.ack", ack, 3'b010);
    chk("mid_retry.s", s, 16'h0BEE);
    chk_model("mid_retry");
    req = 3'b000;

`ifdef WR_ARB_LOCK_EN
    do_reset();
    req = 3'b011; lock = 3'b001; req_sel = 6'b000100; req_data = {16'h0, 16'h0021, 16'h0020};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lock.ack", ack, (k % 2 == 0) ? 3'b001 : 3'b010);
      chk_model("lock");
    end
    lock = 3'b000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("unlock.ack", ack, (k % 2 == 0) ? 3'b001 : 3'b010);
      chk_model("unlock");
    end
    req = 3'b000;
`endif

    // randomized requesters obeying the hold-until-ack protocol
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step();
      chk_model("rand");
      chk("rand.onehot", $countones(ack) <= 1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        if (req[i] && m_ack[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          req_sel[2*i +: 2] = 2'($urandom_range(0, 3));
          req_data[N*i +: N] = N'($urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_sel[2*i +: 2] = 2'($urandom_range(0, 3));
          req_data[N*i +: N] = N'($urandom);
        end
      end
`ifdef WR_ARB_LOCK_EN
      lock = 3'($urandom_range(0, 7));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
